// File: rtl/hx8352_pkg.sv
// Shared definitions for the HX8352 power-on init sequencer: ROM entry
// layout, op encodings and sequencer states.
package hx8352_pkg;

  localparam int ENTRY_W = 18;
  localparam int DATA_W  = 16;

  localparam logic [1:0] OP_CMD   = 2'b00;
  localparam logic [1:0] OP_DATA  = 2'b01;
  localparam logic [1:0] OP_DELAY = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_DELAY,
    ST_DONE
  } seq_state_t;

  // Packs an op and its 16-bit operand into one ROM word.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [1:0]        op,
                                                    input logic [DATA_W-1:0] value);
    return {op, value};
  endfunction

endpackage

// File: rtl/hx8352_init_rom.sv
// Init-command table for the HX8352: synchronous read, one cycle of latency.
// Addresses past the table read as END so a short table always terminates.
module hx8352_init_rom
  import hx8352_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic               clk,
  input  logic [AW-1:0]      addr,
  output logic [ENTRY_W-1:0] entry
);

  always_ff @(posedge clk) begin
    case (addr)
      AW'(0):  entry <= pack_entry(OP_CMD,   16'h0083);
      AW'(1):  entry <= pack_entry(OP_DATA,  16'h0002);
      AW'(2):  entry <= pack_entry(OP_DELAY, 16'd5);
      AW'(3):  entry <= pack_entry(OP_CMD,   16'h0085);
      AW'(4):  entry <= pack_entry(OP_DATA,  16'h0003);
      AW'(5):  entry <= pack_entry(OP_END,   16'h0000);
      default: entry <= pack_entry(OP_END,   16'h0000);
    endcase
  end

endmodule

// File: rtl/hx8352_init_sequencer.sv
// Walks the HX8352 init ROM after panel reset, issuing bus writes and ms
// delays, then passes the bus writer through to the user requester.
module hx8352_init_sequencer
  import hx8352_pkg::*;
#(
  parameter int ROM_DEPTH  = 64,
  parameter int CLK_PER_MS = 50_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lcd_rst_done,
  output logic              bus_valid,
  output logic              bus_rs,
  output logic [DATA_W-1:0] bus_data,
  input  logic              bus_ready,
  input  logic              user_valid,
  input  logic              user_rs,
  input  logic [DATA_W-1:0] user_data,
  output logic              user_ready,
  output logic              init_done,
  output logic              busy
);

  localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(ROM_DEPTH - 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_MS - 1);

  seq_state_t          state_reg, state_next;
  logic [AW-1:0]       addr_reg, addr_next;
  logic                fetch_wait_reg, fetch_wait_next;
  logic [PW-1:0]       presc_reg, presc_next;
  logic [DATA_W-1:0]   ms_cnt_reg, ms_cnt_next;
  logic                rs_reg, rs_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                init_done_reg, init_done_next;
  logic                advance;

  logic [ENTRY_W-1:0]  rom_word;
  logic [1:0]          rom_op;
  logic [DATA_W-1:0]   rom_value;

  hx8352_init_rom #(
    .AW (AW)
  ) u_rom (
    .clk   (clk),
    .addr  (addr_reg),
    .entry (rom_word)
  );

  assign rom_op    = rom_word[ENTRY_W-1:DATA_W];
  assign rom_value = rom_word[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      fetch_wait_reg <= 1'b0;
      presc_reg      <= '0;
      ms_cnt_reg     <= '0;
      rs_reg         <= 1'b0;
      data_reg       <= '0;
      init_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      fetch_wait_reg <= fetch_wait_next;
      presc_reg      <= presc_next;
      ms_cnt_reg     <= ms_cnt_next;
      rs_reg         <= rs_next;
      data_reg       <= data_next;
      init_done_reg  <= init_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    fetch_wait_next = fetch_wait_reg;
    presc_next      = presc_reg;
    ms_cnt_next     = ms_cnt_reg;
    rs_next         = rs_reg;
    data_next       = data_reg;
    init_done_next  = init_done_reg;
    advance         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (lcd_rst_done) begin
          state_next      = ST_FETCH;
          addr_next       = '0;
          fetch_wait_next = 1'b0;
        end
      end

      // First FETCH cycle lets the ROM register addr_reg; the second decodes it.
      ST_FETCH: begin
        if (!fetch_wait_reg) begin
          fetch_wait_next = 1'b1;
        end else begin
          fetch_wait_next = 1'b0;
          case (rom_op)
            OP_CMD, OP_DATA: begin
              state_next = ST_ISSUE;
              rs_next    = rom_op[0];
              data_next  = rom_value;
            end
            OP_DELAY: begin
              state_next  = ST_DELAY;
              ms_cnt_next = rom_value;
              presc_next  = '0;
            end
            default: begin
              state_next     = ST_DONE;
              init_done_next = 1'b1;
            end
          endcase
        end
      end

      ST_ISSUE: begin
        if (bus_ready) begin
          advance = 1'b1;
        end
      end

      ST_DELAY: begin
        if (ms_cnt_reg == '0) begin
          advance = 1'b1;
        end else if (presc_reg == PRESC_MAX) begin
          presc_next  = '0;
          ms_cnt_next = ms_cnt_reg - 1'b1;
        end else begin
          presc_next = presc_reg + 1'b1;
        end
      end

      ST_DONE: begin
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // The last ROM slot finishes the sequence even without an END entry.
    if (advance) begin
      if (addr_reg == LAST_ADDR) begin
        state_next     = ST_DONE;
        init_done_next = 1'b1;
      end else begin
        state_next = ST_FETCH;
        addr_next  = addr_reg + 1'b1;
      end
    end

    // Panel reset re-asserted: drop everything, including a pending write.
    if ((state_reg != ST_IDLE) && !lcd_rst_done) begin
      state_next      = ST_IDLE;
      addr_next       = '0;
      fetch_wait_next = 1'b0;
      presc_next      = '0;
      ms_cnt_next     = '0;
      init_done_next  = 1'b0;
    end
  end

  assign bus_valid  = (state_reg == ST_DONE) ? user_valid : (state_reg == ST_ISSUE);
  assign bus_rs     = (state_reg == ST_DONE) ? user_rs    : rs_reg;
  assign bus_data   = (state_reg == ST_DONE) ? user_data  : data_reg;
  assign user_ready = (state_reg == ST_DONE) && bus_ready;
  assign init_done  = init_done_reg;
  assign busy       = (state_reg == ST_FETCH) || (state_reg == ST_ISSUE) ||
                      (state_reg == ST_DELAY);

endmodule
